aes_decipher_iter: RTL and testbench
====================================

// Module: aes_decipher_iter
//
// PURPOSE
// Iterative AES inverse cipher engine.
// - Decrypts one 128-bit block for AES-128/192/256.
// - Drives round_key_addr to an external key memory, which returns round_key combinationally.
// - InvSubBytes throughput is set by SBOX_LANES (aes_inv_sbox instances).
// - Successor to the single-round decipher datapath; adds round sequencing, key-length modes and area/latency scaling.
//
// PARAMETERS
// SBOX_LANES  4  Bytes substituted per cycle; legal values 1,2,4,8,16; any other value is an elaboration error.
//
// PORTS
// clk             in   1    Clock; all flops on the rising edge.
// reset           in   1    Asynchronous, active-high reset.
// next            in   1    Start request; accepted only when ready=1.
// keylen          in   2    00 AES-128 (Nr=10), 01 AES-192 (Nr=12), 10 AES-256 (Nr=14), 11 treated as 00.
// block           in   128  Ciphertext; byte 0 in [127:120], column-major.
// round_key_addr  out  4    Index of the round key required this cycle.
// round_key       in   128  Round key for round_key_addr, valid in the same cycle.
// new_block       out  128  State register; plaintext when ready=1 after a completed operation.
// ready           out  1    1 = idle or done; 0 = busy.
//
// BEHAVIOUR
// - Reset values: ready=1, new_block=0, round_key_addr=0; FSM=IDLE; round_ctr=0; byte_ctr=0.
// - Reset mid-operation aborts immediately to these values; no partial result is kept.
// - FSM states: IDLE, INIT, SUB, MIX.
// - IDLE:
//   - next=1 at an edge: latch block into state, latch Nr from keylen, round_ctr=Nr-1, ready<=0, go to INIT.
//   - next=0: hold state and new_block.
// - INIT (1 cycle):
//   - round_key_addr=Nr.
//   - state <= state ^ round_key.
//   - byte_ctr <= 0; go to SUB.
// - SUB (16/SBOX_LANES cycles):
//   - Bytes [byte_ctr*L +: L] pass through the inv sboxes and are written back in place (L = SBOX_LANES).
//   - byte_ctr increments each cycle and wraps to 0 on the last cycle, then go to MIX.
//   - InvSubBytes is applied before InvShiftRows; the two operations commute.
// - MIX (1 cycle):
//   - round_key_addr=round_ctr.
//   - state <= InvMixColumns(InvShiftRows(state) ^ round_key) when round_ctr!=0.
//   - state <= InvShiftRows(state) ^ round_key when round_ctr==0 (final round, no InvMixColumns).
//   - round_ctr!=0: decrement round_ctr, go to SUB.
//   - round_ctr==0: ready<=1, go to IDLE.
// - round_key_addr=0 in IDLE and SUB.
// - Latency: ready returns high exactly 1+Nr*(16/L+1) edges after the edge that accepted next.
//   - L=4,  Nr=10: 51.
//   - L=16, Nr=14: 29.
//   - L=1,  Nr=10: 171.
// - next while ready=0 is ignored.
// - Changes to block or keylen while busy are ignored; both are sampled only at accept.
// - next held high through completion starts a new operation on the edge after ready rises.
//   - The result is visible for exactly one cycle.
// - GF arithmetic: 8-bit, polynomial 0x11b; InvMixColumns coefficients 0e,0b,0d,09.
// - new_block is the state register at all times; it is meaningful only when ready=1.
//
// TESTING
// 1. FIPS-197 C.1 (L=4): key 000102..0f, keylen=00, block=69c4e0d86a7b0430d8cdb78070b4c55a
//    -> new_block=00112233445566778899aabbccddeeff; ready low for exactly 51 cycles.
// 2. C.2 (keylen=01, key 00..17), block=dda97ca4864cdfe06eaf70a0ec0d7191
//    -> same plaintext; round_key_addr sequence 12,11,...,0.
// 3. C.3 (keylen=10, key 00..1f), block=8ea2b7ca516745bfeafc49904b496089
//    -> same plaintext; rerun with SBOX_LANES=1,2,8,16: identical result, latency 1+14*(16/L+1).
// 4. next pulsed at cycles 5, 20 and 40 of a busy C.1 run -> ignored; one result only; ready timing unchanged.
// 5. reset asserted at cycle 25 of a C.3 run, released, C.1 started
//    -> outputs return to reset values asynchronously; C.1 result is correct.
// 6. keylen=11 with the C.1 vector -> behaves as AES-128 (51 cycles, same plaintext).
//    Also: next held high -> back-to-back operations with one ready cycle between them.

Source files
------------

// File: rtl/aes_decipher_iter.sv
// Iterative AES inverse cipher for AES-128/192/256.
// One 128-bit block is decrypted per operation. Round keys come from an
// external memory addressed by round_key_addr, which answers in the same cycle.
// InvSubBytes runs SBOX_LANES bytes per cycle; the remaining inverse round
// steps are done together in a single cycle.

module aes_inv_sbox (
    input  logic [7:0] sub_byte,
    output logic [7:0] inv_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign inv_byte = INV_SBOX[sub_byte];

endmodule

module aes_decipher_iter #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [1:0]   keylen,
    input  logic [127:0] block,
    output logic [3:0]   round_key_addr,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam int         GROUPS     = 16 / SBOX_LANES;
    localparam logic [3:0] LAST_GROUP = 4'(GROUPS - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("aes_decipher_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SUB,
        MIX
    } fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [3:0]   round_ctr_reg, round_ctr_next;
    logic [3:0]   byte_ctr_reg, byte_ctr_next;
    logic         ready_reg, ready_next;
    logic [127:0] sub_state;
    logic [7:0]   sbox_in  [SBOX_LANES];
    logic [7:0]   sbox_out [SBOX_LANES];

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant; only coefficients below 16 are needed here.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
               (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Byte (row r, column c) sits at index r+4c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    // Round counter starts at Nr-1; keylen 11 falls back to AES-128.
    function automatic logic [3:0] first_round(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd11;
            2'b10:   return 4'd13;
            default: return 4'd9;
        endcase
    endfunction

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        aes_inv_sbox u_sbox (
            .sub_byte (sbox_in[j]),
            .inv_byte (sbox_out[j])
        );
    end

    // Route the byte group selected by byte_ctr into the sbox lanes.
    always_comb begin
        for (int j = 0; j < SBOX_LANES; j++) begin
            sbox_in[j] = 8'h00;
        end
        for (int g = 0; g < GROUPS; g++) begin
            if (byte_ctr_reg == 4'(g)) begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    sbox_in[j] = state_reg[127 - 8*(g*SBOX_LANES + j) -: 8];
                end
            end
        end
    end

    // Write the substituted bytes back in place, leaving other bytes untouched.
    always_comb begin
        sub_state = state_reg;
        for (int g = 0; g < GROUPS; g++) begin
            if (byte_ctr_reg == 4'(g)) begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    sub_state[127 - 8*(g*SBOX_LANES + j) -: 8] = sbox_out[j];
                end
            end
        end
    end

    // Sequencing and datapath updates; INIT fetches key Nr as round_ctr+1.
    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        round_ctr_next = round_ctr_reg;
        byte_ctr_next  = byte_ctr_reg;
        ready_next     = ready_reg;
        round_key_addr = 4'd0;
        case (fsm_reg)
            IDLE: begin
                if (next) begin
                    state_next     = block;
                    round_ctr_next = first_round(keylen);
                    ready_next     = 1'b0;
                    fsm_next       = INIT;
                end
            end
            INIT: begin
                round_key_addr = round_ctr_reg + 4'd1;
                state_next     = state_reg ^ round_key;
                byte_ctr_next  = 4'd0;
                fsm_next       = SUB;
            end
            SUB: begin
                state_next = sub_state;
                if (byte_ctr_reg == LAST_GROUP) begin
                    byte_ctr_next = 4'd0;
                    fsm_next      = MIX;
                end else begin
                    byte_ctr_next = byte_ctr_reg + 4'd1;
                end
            end
            MIX: begin
                round_key_addr = round_ctr_reg;
                if (round_ctr_reg != 4'd0) begin
                    state_next     = inv_mix_columns(inv_shift_rows(state_reg) ^ round_key);
                    round_ctr_next = round_ctr_reg - 4'd1;
                    fsm_next       = SUB;
                end else begin
                    state_next = inv_shift_rows(state_reg) ^ round_key;
                    ready_next = 1'b1;
                    fsm_next   = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            round_ctr_reg <= 4'd0;
            byte_ctr_reg  <= 4'd0;
            ready_reg     <= 1'b1;
        end else begin
            fsm_reg       <= fsm_next;
            state_reg     <= state_next;
            round_ctr_reg <= round_ctr_next;
            byte_ctr_reg  <= byte_ctr_next;
            ready_reg     <= ready_next;
        end
    end

    assign new_block = state_reg;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Testbench for aes_decipher_iter: FIPS-197 appendix C vectors on five lane
// widths, with busy-time next pulses, mid-run reset and back-to-back starts.

module tb_aes_decipher_iter;

    localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int           MAIN  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   next_v;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   addr    [5];
    logic [127:0] new_blk [5];
    logic [4:0]   rdy;
    logic [127:0] rk      [16];
    logic [7:0]   sbox    [256];
    logic [31:0]  w       [60];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 5; i++) begin : g_dut
        aes_decipher_iter #(.SBOX_LANES(1 << i)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .next           (next_v[i]),
            .keylen         (keylen),
            .block          (block),
            .round_key_addr (addr[i]),
            .round_key      (rk[addr[i]]),
            .new_block      (new_blk[i]),
            .ready          (rdy[i])
        );
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse and affine map, independent of the RTL table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    // Key memory contents for key bytes 00,01,02,... of nk words.
    task automatic load_keys(input int nk);
        int         nr;
        logic [31:0] temp;
        logic [7:0]  rcon;
        nr = nk + 6;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        rcon = 8'h01;
        for (int i = nk; i < 4*(nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic int latency(input int lanes, input int nr);
        return 1 + nr * (16 / lanes + 1);
    endfunction

    // Start one operation on the selected instances, scramble the inputs while busy,
    // and time instance `watch`; a non-negative first_addr checks the key address walk.
    task automatic applyStimulus(input logic [4:0] sel, input logic [1:0] kl, input logic [127:0] ct,
                                 input int watch, input int first_addr, output int cycles);
        int exp_addr;
        @(negedge clk);
        keylen = kl;
        block  = ct;
        next_v = sel;
        @(posedge clk);
        #1;
        next_v   = '0;
        block    = ~ct;
        keylen   = ~kl;
        cycles   = 0;
        exp_addr = first_addr;
        while (rdy[watch] == 1'b0 && cycles < 400) begin
            if (first_addr >= 0 && addr[watch] != 4'd0) begin
                checkOutput("key_addr", 128'(addr[watch]), 128'(exp_addr));
                exp_addr--;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (first_addr >= 0) checkOutput("key_addr_count", 128'(exp_addr), 128'd0);
    endtask

    initial begin
        int cyc;
        build_sbox();
        reset  = 1'b1;
        next_v = '0;
        keylen = 2'b00;
        block  = '0;
        #2;
        checkOutput("reset_ready", 128'(rdy[MAIN]), 128'd1);
        checkOutput("reset_block", new_blk[MAIN], 128'd0);
        checkOutput("reset_addr", 128'(addr[MAIN]), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // AES-128
        load_keys(4);
        applyStimulus(5'b00100, 2'b00, CT128, MAIN, 10, cyc);
        checkOutput("c1_plain", new_blk[MAIN], PLAIN);
        checkOutput("c1_latency", 128'(cyc), 128'(latency(4, 10)));

        // AES-192
        load_keys(6);
        applyStimulus(5'b00100, 2'b01, CT192, MAIN, 12, cyc);
        checkOutput("c2_plain", new_blk[MAIN], PLAIN);
        checkOutput("c2_latency", 128'(cyc), 128'(latency(4, 12)));

        // AES-256 on every lane width
        load_keys(8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'(1 << i), 2'b10, CT256, i, (i == MAIN) ? 14 : -1, cyc);
            checkOutput($sformatf("c3_plain_L%0d", 1 << i), new_blk[i], PLAIN);
            checkOutput($sformatf("c3_latency_L%0d", 1 << i), 128'(cyc), 128'(latency(1 << i, 14)));
        end

        // next pulses while busy are ignored
        load_keys(4);
        fork
            applyStimulus(5'b00100, 2'b00, CT128, MAIN, -1, cyc);
            begin
                repeat (6) @(negedge clk);
                next_v[MAIN] = 1'b1;
                @(negedge clk);
                next_v[MAIN] = 1'b0;
                repeat (14) @(negedge clk);
                next_v[MAIN] = 1'b1;
                @(negedge clk);
                next_v[MAIN] = 1'b0;
                repeat (19) @(negedge clk);
                next_v[MAIN] = 1'b1;
                @(negedge clk);
                next_v[MAIN] = 1'b0;
            end
        join
        checkOutput("busy_next_plain", new_blk[MAIN], PLAIN);
        checkOutput("busy_next_latency", 128'(cyc), 128'd51);
        repeat (5) @(negedge clk);
        checkOutput("idle_hold_ready", 128'(rdy[MAIN]), 128'd1);
        checkOutput("idle_hold_block", new_blk[MAIN], PLAIN);

        // reset in the middle of an AES-256 run
        load_keys(8);
        @(negedge clk);
        keylen       = 2'b10;
        block        = CT256;
        next_v[MAIN] = 1'b1;
        @(posedge clk);
        #1;
        next_v[MAIN] = 1'b0;
        repeat (24) @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", 128'(rdy[MAIN]), 128'd0);
        reset = 1'b1;
        #1;
        checkOutput("abort_ready", 128'(rdy[MAIN]), 128'd1);
        checkOutput("abort_block", new_blk[MAIN], 128'd0);
        checkOutput("abort_addr", 128'(addr[MAIN]), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_block", new_blk[MAIN], 128'd0);
        load_keys(4);
        applyStimulus(5'b00100, 2'b00, CT128, MAIN, 10, cyc);
        checkOutput("after_reset_plain", new_blk[MAIN], PLAIN);
        checkOutput("after_reset_latency", 128'(cyc), 128'd51);

        // keylen 11 behaves as AES-128
        applyStimulus(5'b00100, 2'b11, CT128, MAIN, 10, cyc);
        checkOutput("kl11_plain", new_blk[MAIN], PLAIN);
        checkOutput("kl11_latency", 128'(cyc), 128'd51);

        // next held high: back-to-back operations, result visible one cycle
        @(negedge clk);
        keylen       = 2'b00;
        block        = CT128;
        next_v[MAIN] = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (rdy[MAIN] == 1'b0 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("b2b_first_latency", 128'(cyc), 128'd51);
        checkOutput("b2b_first_plain", new_blk[MAIN], PLAIN);
        @(posedge clk);
        #1;
        checkOutput("b2b_restart", 128'(rdy[MAIN]), 128'd0);
        cyc = 0;
        while (rdy[MAIN] == 1'b0 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        next_v[MAIN] = 1'b0;
        checkOutput("b2b_second_latency", 128'(cyc), 128'd51);
        checkOutput("b2b_second_plain", new_blk[MAIN], PLAIN);
        repeat (3) @(negedge clk);
        checkOutput("b2b_stopped", 128'(rdy[MAIN]), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
